// File: rtl/avs_arbiter.sv
// Two-master Avalon-MM arbiter in front of one shared slave: alternating grants
// under contention, one idle turnaround cycle between grants, stall-timeout abort.
module avs_arbiter #(
    parameter int                      C_ADDR_WIDTH = 8,
    parameter int                      C_DATA_WIDTH = 32,
    parameter int                      C_TIMEOUT    = 255,  // legal range 2..65535
    parameter logic [C_DATA_WIDTH-1:0] C_ERR_DATA   = C_DATA_WIDTH'(32'hDEADBEEF)
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,

    input  logic [C_ADDR_WIDTH-1:0] m0_address,
    input  logic                    m0_read,
    input  logic                    m0_write,
    input  logic [C_DATA_WIDTH-1:0] m0_writedata,
    output logic [C_DATA_WIDTH-1:0] m0_readdata,
    output logic                    m0_waitrequest,

    input  logic [C_ADDR_WIDTH-1:0] m1_address,
    input  logic                    m1_read,
    input  logic                    m1_write,
    input  logic [C_DATA_WIDTH-1:0] m1_writedata,
    output logic [C_DATA_WIDTH-1:0] m1_readdata,
    output logic                    m1_waitrequest,

    output logic [C_ADDR_WIDTH-1:0] s_address,
    output logic                    s_read,
    output logic                    s_write,
    output logic [C_DATA_WIDTH-1:0] s_writedata,
    input  logic [C_DATA_WIDTH-1:0] s_readdata,
    input  logic                    s_waitrequest,

    output logic                    timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    localparam logic [15:0] STALL_LIMIT = 16'(C_TIMEOUT - 1);

    state_t      state;
    logic        last_grant;
    logic [15:0] stall_cnt;

    logic m0_req;
    logic m1_req;
    logic busy;
    logic grant1;
    logic act_req;
    logic timeout_hit;

    assign m0_req      = m0_read | m0_write;
    assign m1_req      = m1_read | m1_write;
    assign busy        = (state == BUSY0) || (state == BUSY1);
    assign grant1      = (state == BUSY1);
    assign act_req     = grant1 ? m1_req : m0_req;
    // A master that has already dropped its request cannot be timed out.
    assign timeout_hit = busy && act_req && s_waitrequest && (stall_cnt == STALL_LIMIT);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            stall_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (m0_req && m1_req) state <= last_grant ? BUSY0 : BUSY1;
                    else if (m0_req)      state <= BUSY0;
                    else if (m1_req)      state <= BUSY1;
                end
                BUSY0, BUSY1: begin
                    if (!act_req) begin
                        state <= IDLE;
                    end else if (!s_waitrequest || timeout_hit) begin
                        state      <= IDLE;
                        last_grant <= grant1;
                    end else begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset forces the idle view immediately so an access cut by reset never
    // appears to complete on the master side.
    // NOTE: every output gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        m0_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_waitrequest = 1'b1;
        m1_readdata    = '0;
        timeout_err    = 1'b0;
        if (!sys_rst) begin
            case (state)
                BUSY0: begin
                    s_address      = m0_address;
                    s_read         = m0_read;
                    s_write        = m0_write;
                    s_writedata    = m0_writedata;
                    m0_waitrequest = s_waitrequest & ~timeout_hit;
                    m0_readdata    = timeout_hit ? C_ERR_DATA : s_readdata;
                    timeout_err    = timeout_hit;
                end
                BUSY1: begin
                    s_address      = m1_address;
                    s_read         = m1_read;
                    s_write        = m1_write;
                    s_writedata    = m1_writedata;
                    m1_waitrequest = s_waitrequest & ~timeout_hit;
                    m1_readdata    = timeout_hit ? C_ERR_DATA : s_readdata;
                    timeout_err    = timeout_hit;
                end
                default: ;
            endcase
        end
    end

endmodule
